// File: rtl/ixc_cap_wait_ctl.sv
// ixc_cap_wait_ctl: round-robin capture-request controller driving bpWait; define IXC_CAPWAIT_STATS_EN to add capCount/maxLat
module ixc_cap_wait_ctl #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic             bClk,
  input  logic             bRstN,
  input  logic [NREQ-1:0]  capReq,
  input  logic             bcLatchEn,
  input  logic             bpHalt,
  output logic             en,
  output logic [NREQ-1:0]  capGnt,
  output logic [NREQ-1:0]  capDone,
  output logic             capErr,
  output logic             busy
`ifdef IXC_CAPWAIT_STATS_EN
  ,
  output logic [31:0]      capCount,
  output logic [CNT_W-1:0] maxLat
`endif
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] H_LAST = 8'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HOLD, S_DONE, S_ERR} state_t;

  state_t state_q;
  logic [PW-1:0] ptr_q, win_idx;
  logic [CNT_W-1:0] tcnt_q;
  logic [7:0] hcnt_q;
  logic [NREQ-1:0] gnt_q, done_q, req_rot;
  logic en_q, err_q, busy_q, win_vld, fin, arb, wait_run, to_done, to_err;

  // The finishing owner still holds capReq during its capDone cycle, so it is masked out
  assign req_rot  = NREQ'({capReq & ~done_q, capReq & ~done_q} >> ptr_q);
  assign fin      = (state_q == S_DONE) || (state_q == S_ERR);
  assign arb      = !bpHalt && win_vld && ((state_q == S_IDLE) || fin);
  assign wait_run = !bpHalt && (state_q == S_WAIT);
  assign to_done  = (wait_run && bcLatchEn && (HOLD_CYC == 0)) ||
                    (!bpHalt && (state_q == S_HOLD) && (hcnt_q == H_LAST));
  assign to_err   = wait_run && !bcLatchEn && (tcnt_q == T_LAST);

  // Round-robin search: first pending requester at or after the pointer
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_vld = 1'b1;
        win_idx = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // Capture FSM; DONE/ERR arbitrate directly so en is low for a single cycle between captures
  always_ff @(posedge bClk or negedge bRstN) begin
    if (!bRstN) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      tcnt_q  <= '0;
      hcnt_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= '0;
      if (arb) begin
        state_q <= S_WAIT;
        en_q    <= 1'b1;
        busy_q  <= 1'b1;
        gnt_q   <= NREQ'(1) << win_idx;
        ptr_q   <= PW'((int'(win_idx) + 1) % NREQ);
        tcnt_q  <= '0;
      end else if (fin) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else if (to_done || to_err) begin
        state_q <= to_err ? S_ERR : S_DONE;
        en_q    <= 1'b0;
        gnt_q   <= '0;
        done_q  <= gnt_q;
        err_q   <= err_q | to_err;
      end else if (wait_run && bcLatchEn) begin
        state_q <= S_HOLD;
        hcnt_q  <= '0;
      end else if (wait_run) begin
        tcnt_q <= tcnt_q + 1'b1;
      end else if (!bpHalt && (state_q == S_HOLD)) begin
        hcnt_q <= hcnt_q + 1'b1;
      end
    end
  end

  assign en      = en_q;
  assign capGnt  = gnt_q;
  assign capDone = done_q;
  assign capErr  = err_q;
  assign busy    = busy_q;

`ifdef IXC_CAPWAIT_STATS_EN
  logic [31:0] cnt_q;
  logic [CNT_W-1:0] max_q, lat;

  // WAIT length is the frozen timeout count plus one, saturated at the counter width
  assign lat = (&tcnt_q) ? tcnt_q : tcnt_q + 1'b1;

  // Count every completion (including timeouts) and track the longest WAIT
  always_ff @(posedge bClk or negedge bRstN) begin
    if (!bRstN) begin
      cnt_q <= '0;
      max_q <= '0;
    end else if (to_done || to_err) begin
      cnt_q <= cnt_q + 1'b1;
      if (lat > max_q) max_q <= lat;
    end
  end

  assign capCount = cnt_q;
  assign maxLat   = max_q;
`endif
endmodule

// File: tb/tb_ixc_cap_wait_ctl.sv
// tb_ixc_cap_wait_ctl: vector table, directed corner cases and randomized model comparison for ixc_cap_wait_ctl
module tb_ixc_cap_wait_ctl;
  localparam int N = 4, HOLD = 2, TMO = 8, CW = 11;

  logic bClk = 1'b0, bRstN = 1'b1, bcLatchEn = 1'b0, bpHalt = 1'b0;
  logic [N-1:0] capReq = '0;
  logic en, capErr, busy;
  logic [N-1:0] capGnt, capDone;
`ifdef IXC_CAPWAIT_STATS_EN
  logic [31:0] capCount;
  logic [CW-1:0] maxLat;
`endif
  int checks = 0, errors = 0;

  ixc_cap_wait_ctl #(.NREQ(N), .HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
    .bClk(bClk), .bRstN(bRstN), .capReq(capReq), .bcLatchEn(bcLatchEn), .bpHalt(bpHalt),
    .en(en), .capGnt(capGnt), .capDone(capDone), .capErr(capErr), .busy(busy)
`ifdef IXC_CAPWAIT_STATS_EN
    , .capCount(capCount), .maxLat(maxLat)
`endif
  );

  always #5 bClk = ~bClk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic rst;
    logic [N-1:0] req;
    logic latch, halt, en;
    logic [N-1:0] gnt, done;
    logic err, busy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int rst, req, l, h, e, g, d, er, b);
    tbl.push_back('{1'(rst), N'(req), 1'(l), 1'(h), 1'(e), N'(g), N'(d), 1'(er), 1'(b)});
  endtask

  task automatic chk(input string nm, input int e, g, d, er, b);
    checks++;
    if ({en, capGnt, capDone, capErr, busy} !== {1'(e), N'(g), N'(d), 1'(er), 1'(b)}) begin
      errors++;
      $display("FAIL %s: got en=%b gnt=%b done=%b err=%b busy=%b, expected en=%b gnt=%b done=%b err=%b busy=%b",
               nm, en, capGnt, capDone, capErr, busy, 1'(e), N'(g), N'(d), 1'(er), 1'(b));
    end
  endtask

`ifdef IXC_CAPWAIT_STATS_EN
  task automatic chk_stats(input string nm, input int c, m);
    checks++;
    if (capCount !== 32'(c) || maxLat !== CW'(m)) begin
      errors++;
      $display("FAIL %s: capCount=%0d maxLat=%0d, expected %0d/%0d", nm, capCount, maxLat, c, m);
    end
  endtask
`endif

  // Called at a falling edge; returns at the next falling edge
  task automatic step(input int r, l, h);
    capReq = N'(r);
    bcLatchEn = 1'(l);
    bpHalt = 1'(h);
    @(posedge bClk);
    @(negedge bClk);
  endtask

  task automatic do_reset();
    capReq = '0;
    bcLatchEn = 1'b0;
    bpHalt = 1'b0;
    bRstN = 1'b0;
    #2;
    chk("reset", 0, 0, 0, 0, 0);
`ifdef IXC_CAPWAIT_STATS_EN
    chk_stats("reset_stats", 0, 0);
`endif
    @(negedge bClk);
    bRstN = 1'b1;
  endtask

  // Reference model: phase 0 idle, 1 waiting for latch, 2 holding, 3 completion pulse
  int m_phase, m_owner, m_down, m_wait, m_hold, m_ptr, m_cnt, m_max;
  logic m_err;

  task automatic m_reset();
    m_phase = 0; m_owner = -1; m_down = -1; m_wait = 0; m_hold = 0;
    m_ptr = 0; m_cnt = 0; m_max = 0; m_err = 1'b0;
  endtask

  task automatic m_fin(input logic e);
    m_phase = 3;
    m_down = m_owner;
    m_owner = -1;
    m_err = m_err | e;
    m_cnt++;
    if (m_wait > m_max) m_max = m_wait;
  endtask

  task automatic m_step(input logic [N-1:0] r, input logic l, h);
    int excl, i;
    excl = -1;
    if (m_phase == 3) begin
      excl = m_down;
      m_phase = 0;
    end else if (!h && m_phase == 1) begin
      m_wait++;
      if (l && HOLD == 0) m_fin(1'b0);
      else if (l) begin
        m_phase = 2;
        m_hold = 0;
      end else if (m_wait == TMO) m_fin(1'b1);
    end else if (!h && m_phase == 2) begin
      m_hold++;
      if (m_hold == HOLD) m_fin(1'b0);
    end
    if (m_phase == 0 && !h) begin
      for (int d = 0; d < N; d++) begin
        i = (m_ptr + d) % N;
        if (r[i] && i != excl) begin
          m_owner = i;
          m_ptr = (i + 1) % N;
          m_phase = 1;
          m_wait = 0;
          break;
        end
      end
    end
  endtask

  int lens[3] = '{2, 5, 3};
  logic [N-1:0] r, pd;
  logic rl, rh, act;

  initial begin
    #1;
    // single capture: latch on third WAIT cycle, en high for 3 WAIT + 2 HOLD cycles
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 1, 1, 0, 0, 1);
    add(0, 1, 1, 0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // all four requesting: round-robin order with one en-low cycle between captures
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int g = 0; g < 5; g++) begin
      add(0, 15, 0, 0, 1, 1 << (g % N), 0, 0, 1);
      add(0, 15, 0, 0, 1, 1 << (g % N), 0, 0, 1);
      add(0, 15, 1, 0, 1, 1 << (g % N), 0, 0, 1);
      add(0, 15, 0, 0, 1, 1 << (g % N), 0, 0, 1);
      add(0, 15, 0, 0, 0, 0, 1 << (g % N), 0, 1);
    end
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      else begin
        step(int'(tbl[i].req), int'(tbl[i].latch), int'(tbl[i].halt));
        chk($sformatf("vec%0d", i), int'(tbl[i].en), int'(tbl[i].gnt), int'(tbl[i].done),
            int'(tbl[i].err), int'(tbl[i].busy));
      end
    end

    // timeout after TMO WAIT cycles, sticky error, next capture still served
    do_reset();
    for (int k = 0; k < TMO; k++) begin
      step(1, 0, 0);
      chk("tmo_wait", 1, 1, 0, 0, 1);
    end
    step(1, 0, 0); chk("tmo_err", 0, 0, 1, 1, 1);
    step(0, 0, 0); chk("tmo_idle", 0, 0, 0, 1, 0);
    step(1, 0, 0); chk("tmo_regrant", 1, 1, 0, 1, 1);
    step(1, 1, 0); chk("tmo_hold", 1, 1, 0, 1, 1);
    step(1, 0, 0); chk("tmo_hold2", 1, 1, 0, 1, 1);
    step(1, 0, 0); chk("tmo_done", 0, 0, 1, 1, 1);
    step(0, 0, 0); chk("tmo_sticky", 0, 0, 0, 1, 0);

    // halt: no arbitration in IDLE, latch ignored and counter frozen in WAIT
    do_reset();
    step(1, 0, 1); chk("halt_idle", 0, 0, 0, 0, 0);
    step(1, 0, 0); chk("halt_w0", 1, 1, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 1);
      chk("halt_latch_ignored", 1, 1, 0, 0, 1);
    end
    step(1, 0, 0); chk("halt_resume", 1, 1, 0, 0, 1);
    step(1, 1, 0); chk("halt_h0", 1, 1, 0, 0, 1);
    step(1, 0, 0); chk("halt_h1", 1, 1, 0, 0, 1);
    step(1, 0, 0); chk("halt_done", 0, 0, 1, 0, 1);
    step(0, 0, 0); chk("halt_idle2", 0, 0, 0, 0, 0);
    step(1, 0, 0); chk("frz_w0", 1, 1, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 1);
      chk("frz_halted", 1, 1, 0, 0, 1);
    end
    for (int k = 1; k < TMO; k++) begin
      step(1, 0, 0);
      chk("frz_wait", 1, 1, 0, 0, 1);
    end
    step(1, 0, 0); chk("frz_err", 0, 0, 1, 1, 1);

    // asynchronous reset during HOLD, pointer back to requester 0
    do_reset();
    step(1, 0, 0);
    step(1, 1, 0); chk("pre_rst_hold", 1, 1, 0, 0, 1);
    #2 bRstN = 1'b0;
    #1 chk("async_rst", 0, 0, 0, 0, 0);
    @(negedge bClk);
    bRstN = 1'b1;
    step(15, 0, 0); chk("rr_ptr_reset", 1, 1, 0, 0, 1);

`ifdef IXC_CAPWAIT_STATS_EN
    // WAIT lengths 2, 5, 3
    do_reset();
    foreach (lens[j]) begin
      step(1, 0, 0);
      for (int k = 1; k < lens[j]; k++) step(1, 0, 0);
      step(1, 1, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      chk("stats_done", 0, 0, 1, 0, 1);
      step(0, 0, 0);
    end
    chk_stats("stats_final", 3, 5);
`endif

    // randomized traffic against the reference model
    do_reset();
    m_reset();
    r = '0;
    pd = '0;
    for (int c = 0; c < 4000; c++) begin
      r = r & ~pd;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) r[i] = 1'b1;
        else if ($urandom_range(0, 31) == 0) r[i] = 1'b0;
      end
      rl = ($urandom_range(0, 4) == 0);
      rh = ($urandom_range(0, 7) == 0);
      capReq = r;
      bcLatchEn = rl;
      bpHalt = rh;
      @(posedge bClk);
      m_step(r, rl, rh);
      @(negedge bClk);
      act = (m_phase == 1 || m_phase == 2);
      chk($sformatf("rand%0d", c), int'(act), act ? (1 << m_owner) : 0,
          (m_phase == 3) ? (1 << m_down) : 0, int'(m_err), int'(m_phase != 0));
`ifdef IXC_CAPWAIT_STATS_EN
      chk_stats($sformatf("rand_stats%0d", c), m_cnt, m_max);
`endif
      pd = (m_phase == 3) ? N'(1 << m_down) : '0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
